// File: rtl/bus_sram_responder_if.sv
// Request/ready bus between an initiator and the SRAM responder.
// The initiator holds request high until it sees the one-cycle ready pulse.
interface bus_sram_responder_if;
    logic        i_bus_rw;
    logic        i_bus_request;
    logic        o_bus_ready;
    logic [31:0] i_bus_address;
    logic [31:0] o_bus_rdata;
    logic [31:0] i_bus_wdata;

    modport master (
        output i_bus_rw,
        output i_bus_request,
        output i_bus_address,
        output i_bus_wdata,
        input  o_bus_ready,
        input  o_bus_rdata
    );

    modport slave (
        input  i_bus_rw,
        input  i_bus_request,
        input  i_bus_address,
        input  i_bus_wdata,
        output o_bus_ready,
        output o_bus_rdata
    );
endinterface

// File: rtl/bus_sram_responder.sv
// Word-addressed SRAM behind a request/ready bus with a configurable number of wait states.
// Storage is not cleared by reset; only the control path and read-data register are.
module bus_sram_responder #(
    parameter int unsigned SIZE        = 12,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    bus_sram_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RELEASE
    } state_t;

    state_t            state;
    logic [3:0]        wait_count;
    logic              rw_q;
    logic [SIZE-1:0]   index_q;
    logic [31:0]       wdata_q;
    logic              commit_write;

    logic [31:0]       mem [0:(2**SIZE)-1];

    // Byte-offset and high address bits alias by design.
    logic unused_address_bits;
    assign unused_address_bits = ^{bus.i_bus_address[1:0], bus.i_bus_address[31:SIZE+2]};

    assign commit_write = !i_reset && (state == ACCESS) && (wait_count == '0) && rw_q;

    always_ff @(posedge i_clock) begin
        if (commit_write) begin
            mem[index_q] <= wdata_q;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state           <= IDLE;
            wait_count      <= '0;
            bus.o_bus_ready <= 1'b0;
            bus.o_bus_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.o_bus_ready <= 1'b0;
                    if (bus.i_bus_request) begin
                        rw_q       <= bus.i_bus_rw;
                        index_q    <= bus.i_bus_address[SIZE+1:2];
                        wdata_q    <= bus.i_bus_wdata;
                        wait_count <= 4'(WAIT_STATES);
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wait_count != '0) begin
                        wait_count <= wait_count - 4'd1;
                    end else begin
                        if (!rw_q) begin
                            bus.o_bus_rdata <= mem[index_q];
                        end
                        bus.o_bus_ready <= 1'b1;
                        state           <= RELEASE;
                    end
                end
                RELEASE: begin
                    // A request still held from this transaction must drop before the next one.
                    bus.o_bus_ready <= 1'b0;
                    if (!bus.i_bus_request) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    bus.o_bus_ready <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bus_sram_responder.md
BUS_SRAM_RESPONDER -- requirements
Module: bus_sram_responder

Interface
REQ-001 SHALL have parameter SIZE, default 12, log2 of memory depth in 32-bit words.
REQ-002 SHALL have parameter WAIT_STATES, default 1, extra access cycles inserted before each response (0..15).
REQ-003 SHALL have port i_clock, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port i_reset, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port i_bus_rw, input, 1, 1 = write, 0 = read.
REQ-006 SHALL have port i_bus_request, input, 1, initiator request, held high until o_bus_ready is seen.
REQ-007 SHALL have port o_bus_ready, output, 1, one-cycle completion pulse.
REQ-008 SHALL have port i_bus_address, input, 32, byte address.
REQ-009 SHALL have port o_bus_rdata, output, 32, read data, valid while o_bus_ready = 1.
REQ-010 SHALL have port i_bus_wdata, input, 32, write data.

Function
REQ-011 SHALL contain 2^SIZE x 32-bit storage, word-indexed by i_bus_address[SIZE+1:2].
REQ-012 Address bits [1:0] and [31:SIZE+2] SHALL be ignored: aliasing, no error.
REQ-013 Writes SHALL be full 32-bit words; no byte enables.
REQ-014 Control SHALL be an FSM with states IDLE, ACCESS, RELEASE.
REQ-015 IDLE: when i_bus_request = 1, SHALL latch rw, address and wdata, load the wait counter with WAIT_STATES, and enter ACCESS.
REQ-016 ACCESS with counter != 0: SHALL decrement the counter and stay in ACCESS.
REQ-017 ACCESS with counter = 0: SHALL commit the latched write, or register the read word into o_bus_rdata; SHALL set o_bus_ready = 1; SHALL enter RELEASE.
REQ-018 RELEASE: SHALL clear o_bus_ready after exactly one cycle; SHALL return to IDLE only on the first cycle i_bus_request = 0.
REQ-019 Latency: request sampled at edge N -> o_bus_ready high in the cycle following edge N+1+WAIT_STATES.
REQ-020 Inputs changing after the IDLE sample SHALL NOT affect the transaction in flight.
REQ-021 A request held high past its ready pulse SHALL NOT start a second transaction; a new transaction requires request low for at least one cycle.
REQ-022 On a write, o_bus_rdata SHALL retain its previous value.
REQ-023 o_bus_rdata SHALL hold the last read value between transactions.
REQ-024 Read-after-write to the same word SHALL return the new data in the next transaction.
REQ-025 o_bus_ready SHALL never be high in IDLE or ACCESS.

Reset
REQ-026 While i_reset = 1: state SHALL be IDLE, o_bus_ready = 0, o_bus_rdata = 0, wait counter = 0.
REQ-027 Reset during ACCESS before the commit edge SHALL abort the transaction: no write committed, no ready pulse.
REQ-028 Storage contents SHALL NOT be cleared by reset.
REQ-029 A request high on the first cycle after reset release SHALL be accepted as a new transaction.

Verification
REQ-030 WAIT_STATES=1: write 0xDEADBEEF to 0x10 -> one ready pulse on the 3rd cycle after the request edge; then read 0x10 -> rdata 0xDEADBEEF with ready.
REQ-031 WAIT_STATES=0: read 0x04, request held 5 cycles after ready -> exactly one ready pulse, no second access; drop request, re-request -> new pulse.
REQ-032 SIZE=12: write 0x11111111 to 0x0000_0008, read 0x0000_4008 -> 0x11111111 (alias); read 0x0000_000B -> 0x11111111 (low bits ignored).
REQ-033 WAIT_STATES=3: write 0xA5A5A5A5 to 0x20; assert reset in the 2nd ACCESS cycle -> no ready pulse; read 0x20 -> prior value unchanged.
REQ-034 Change address and wdata during ACCESS -> the latched address and data are used; rdata unchanged after the write.
REQ-035 Back-to-back: write 0x1 to 0x0, one idle cycle, read 0x0 -> 0x00000001; ready count equals request count.
